jietiao_ctrl: RTL and testbench

//  Sequencer for the AM coherent-demodulation datapath: mixer (16x8 mult, fixed latency) -> FIR low-pass (AXI-S).

---
 rtl/jietiao_pkg.sv | 19 +
 rtl/jietiao_scale.sv | 77 +++++++
 rtl/jietiao_ctrl.sv | 152 +++++++++++++++
 tb/tb_jietiao_ctrl.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jietiao_pkg.sv
// Shared constants for the AM demodulator sequencer: FSM state encoding,
// FIR data widths and a counter-width helper.
package jietiao_pkg;

  // FSM state encoding
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;

  // FIR AXI-Stream data widths
  localparam int FIR_IN_W  = 24;
  localparam int FIR_OUT_W = 48;

  // Bits needed to hold values 0..n-1 (at least one bit)
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/jietiao_scale.sv
// Output rescaler: arithmetic right shift of the FIR result, then narrowing
// to OUT_W bits, registered once (latency 1).
// Build option JIETIAO_SAT_EN: clamp to the signed OUT_W range instead of
// wrapping, and report clamping on the sticky o_sat_err flag.
module jietiao_scale
  import jietiao_pkg::*;
#(
  parameter int IN_W  = FIR_OUT_W,
  parameter int OUT_W = 16,
  parameter int SHIFT = 24
) (
  input  logic             clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  input  logic [IN_W-1:0]  i_data,
  output logic [OUT_W-1:0] o_data,
  output logic             o_valid
`ifdef JIETIAO_SAT_EN
  ,
  output logic             o_sat_err
`endif
);

  logic signed [IN_W-1:0] w_shifted;
  logic [OUT_W-1:0]       w_result;
  logic [OUT_W-1:0]       r_data;
  logic                   r_valid;

  assign w_shifted = $signed(i_data) >>> SHIFT;

`ifdef JIETIAO_SAT_EN
  localparam logic [OUT_W-1:0] MAX_V = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] MIN_V = {1'b1, {(OUT_W-1){1'b0}}};

  logic w_pos_ovf;
  logic w_neg_ovf;
  logic r_sat_err;

  // The value fits only when every bit above the OUT_W sign bit equals the sign.
  assign w_pos_ovf = !w_shifted[IN_W-1] && (|w_shifted[IN_W-2:OUT_W-1]);
  assign w_neg_ovf =  w_shifted[IN_W-1] && !(&w_shifted[IN_W-2:OUT_W-1]);
  assign w_result  = w_pos_ovf ? MAX_V : (w_neg_ovf ? MIN_V : w_shifted[OUT_W-1:0]);

  // Sticky clamp indicator, only for samples that are actually emitted
  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      r_sat_err <= 1'b0;
    end else if (i_valid && (w_pos_ovf || w_neg_ovf)) begin
      r_sat_err <= 1'b1;
    end
  end

  assign o_sat_err = r_sat_err;
`else
  // Upper bits are simply discarded in wrap mode.
  logic w_unused;
  assign w_unused = ^w_shifted[IN_W-1:OUT_W];
  assign w_result = w_shifted[OUT_W-1:0];
`endif

  // Output register: data held between strobes, valid is a one-cycle pulse
  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      r_data  <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= i_valid;
      if (i_valid) begin
        r_data <= w_result;
      end
    end
  end

  assign o_data  = r_data;
  assign o_valid = r_valid;

endmodule

// File: rtl/jietiao_ctrl.sv
// Sequencer for the AM coherent-demodulation datapath (mixer -> FIR).
// Aligns sample strobes to the multiplier latency, feeds the FIR, flushes it
// with zeros on stop, drops FIR warm-up outputs, decimates and rescales.
// Build option JIETIAO_SAT_EN: saturating rescale plus sat_err output port.
module jietiao_ctrl
  import jietiao_pkg::*;
#(
  parameter int MULT_LAT = 3,
  parameter int WARMUP   = 64,
  parameter int DECIM    = 8,
  parameter int SHIFT    = 24,
  parameter int OUT_W    = 16
) (
  input  logic                 clk_in,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 stop,
  input  logic                 sample_valid,
  input  logic                 fir_s_tready,
  output logic                 fir_s_tvalid,
  output logic                 feed_zero,
  input  logic                 fir_m_tvalid,
  input  logic [FIR_OUT_W-1:0] fir_m_tdata,
  output logic [OUT_W-1:0]     dem_data,
  output logic                 dem_valid,
  output logic                 busy,
  output logic                 drop_err
`ifdef JIETIAO_SAT_EN
  ,
  output logic                 sat_err
`endif
);

  localparam int WARM_W = cnt_w(WARMUP + 1);
  localparam int ZERO_W = cnt_w(WARMUP);
  localparam int DEC_W  = cnt_w(DECIM);
  localparam logic [WARM_W-1:0] WARM_DONE = WARM_W'(WARMUP);
  localparam logic [ZERO_W-1:0] ZERO_LAST = ZERO_W'(WARMUP - 1);
  localparam logic [DEC_W-1:0]  DEC_LAST  = DEC_W'(DECIM - 1);

  logic [1:0]          r_state;
  logic [MULT_LAT-1:0] r_dly;
  logic [ZERO_W-1:0]   r_zero_cnt;
  logic [WARM_W-1:0]   r_warm_cnt;
  logic [DEC_W-1:0]    r_dec_cnt;
  logic                r_drop_err;

  logic w_start_go;
  logic w_line_empty;
  logic w_tap;
  logic w_zero_phase;
  logic w_zero_acc;
  logic w_flush_done;
  logic w_beat;
  logic w_warm_done;
  logic w_emit;

  assign w_start_go   = (r_state == ST_IDLE) && start;
  assign w_line_empty = (r_dly == '0);
  assign w_tap        = r_dly[MULT_LAT-1];
  // Zero feeding begins only once every in-flight product has been issued.
  assign w_zero_phase = (r_state == ST_FLUSH) && w_line_empty;
  assign w_zero_acc   = w_zero_phase && fir_s_tready;
  assign w_flush_done = w_zero_acc && (r_zero_cnt == ZERO_LAST);

  assign w_beat      = (r_state != ST_IDLE) && fir_m_tvalid;
  assign w_warm_done = (r_warm_cnt == WARM_DONE);
  assign w_emit      = w_beat && w_warm_done && (r_dec_cnt == '0);

  // Control FSM: IDLE -> RUN on start, RUN -> FLUSH on stop, back to IDLE after the zero flush
  always_ff @(posedge clk_in) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:  if (start)        r_state <= ST_RUN;
        ST_RUN:   if (stop)         r_state <= ST_FLUSH;
        ST_FLUSH: if (w_flush_done) r_state <= ST_IDLE;
        default:                    r_state <= ST_IDLE;
      endcase
    end
  end

  // Sample-strobe delay line matching the multiplier latency; only RUN samples enter
  always_ff @(posedge clk_in) begin
    if (!rst) begin
      r_dly <= '0;
    end else begin
      r_dly[0] <= (r_state == ST_RUN) && sample_valid;
      for (int i = 1; i < MULT_LAT; i++) begin
        r_dly[i] <= r_dly[i-1];
      end
    end
  end

  // Count zeros accepted by the FIR during the flush
  always_ff @(posedge clk_in) begin
    if (!rst) begin
      r_zero_cnt <= '0;
    end else if (w_start_go || w_flush_done) begin
      r_zero_cnt <= '0;
    end else if (w_zero_acc) begin
      r_zero_cnt <= r_zero_cnt + ZERO_W'(1);
    end
  end

  // Sticky error: a product reached the FIR while it was not ready (mixer cannot stall)
  always_ff @(posedge clk_in) begin
    if (!rst) begin
      r_drop_err <= 1'b0;
    end else if (w_tap && !fir_s_tready) begin
      r_drop_err <= 1'b1;
    end
  end

  // Output-side counters: skip warm-up beats, then keep one beat in every DECIM
  always_ff @(posedge clk_in) begin
    if (!rst || w_start_go) begin
      r_warm_cnt <= '0;
      r_dec_cnt  <= '0;
    end else if (w_beat) begin
      if (!w_warm_done) begin
        r_warm_cnt <= r_warm_cnt + WARM_W'(1);
      end else begin
        r_dec_cnt <= (r_dec_cnt == DEC_LAST) ? '0 : r_dec_cnt + DEC_W'(1);
      end
    end
  end

  jietiao_scale #(
    .IN_W  (FIR_OUT_W),
    .OUT_W (OUT_W),
    .SHIFT (SHIFT)
  ) u_scale (
    .clk       (clk_in),
    .i_rst_n   (rst),
    .i_valid   (w_emit),
    .i_data    (fir_m_tdata),
    .o_data    (dem_data),
    .o_valid   (dem_valid)
`ifdef JIETIAO_SAT_EN
    ,
    .o_sat_err (sat_err)
`endif
  );

  assign busy         = (r_state != ST_IDLE);
  assign fir_s_tvalid = w_tap || w_zero_phase;
  assign feed_zero    = w_zero_phase;
  assign drop_err     = r_drop_err;

endmodule

// File: tb/tb_jietiao_ctrl.sv
// Self-checking bench for jietiao_ctrl: directed phases with randomized
// stimulus, checked against a behavioural model of the sequencing rules.
// Honours JIETIAO_SAT_EN when the design is built with it.
module tb_jietiao_ctrl;

  localparam int MULT_LAT = 3;
  localparam int WARMUP   = 64;
  localparam int DECIM    = 8;
`ifdef JIETIAO_SAT_EN
  localparam logic [15:0] SAT_EXP = 16'h7FFF;
`else
  localparam logic [15:0] SAT_EXP = 16'hFFFF;
`endif

  logic        clk_in = 1'b0;
  logic        rst, start, stop, sample_valid, fir_s_tready, fir_m_tvalid;
  logic [47:0] fir_m_tdata;
  logic        fir_s_tvalid, feed_zero, dem_valid, busy, drop_err;
  logic [15:0] dem_data;
`ifdef JIETIAO_SAT_EN
  logic        sat_err;
  bit          exp_sat;
`endif

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  bit          exp_tv[0:16383];
  bit          exp_drop;
  logic [15:0] q0[$];
  logic [15:0] q1[$];
  int          wcnt;

  always #5 clk_in = ~clk_in;

  jietiao_ctrl dut (
    .clk_in       (clk_in),
    .rst          (rst),
    .start        (start),
    .stop         (stop),
    .sample_valid (sample_valid),
    .fir_s_tready (fir_s_tready),
    .fir_s_tvalid (fir_s_tvalid),
    .feed_zero    (feed_zero),
    .fir_m_tvalid (fir_m_tvalid),
    .fir_m_tdata  (fir_m_tdata),
    .dem_data     (dem_data),
    .dem_valid    (dem_valid),
    .busy         (busy),
    .drop_err     (drop_err)
`ifdef JIETIAO_SAT_EN
    ,
    .sat_err      (sat_err)
`endif
  );

  task automatic tick();
    @(posedge clk_in);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h cycle=%0d", tag, obs, exp, cyc);
    end
  endtask

  // Reference: signed value of the FIR word divided by 2^24 (floor)
  function automatic longint ref_shift(input logic [47:0] d);
    return longint'($signed(d)) >>> 24;
  endfunction

  // Reference: narrow to 16 bits (clamp or wrap)
  function automatic logic [15:0] ref_out(input longint v);
`ifdef JIETIAO_SAT_EN
    if (v > 32767) return 16'h7FFF;
    if (v < -32768) return 16'h8000;
`endif
    return v[15:0];
  endfunction

  // Output side: beat k kept when k >= WARMUP and (k-WARMUP) is a multiple of DECIM
  task automatic run_out(input int pass);
    int          n17;
    int          gap;
    logic [47:0] d;
    longint      v;
    bit          emit_now;
    n17 = 0;
    for (int k = 0; k < 290; k++) begin
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        fir_m_tvalid = 1'b0;
        fir_m_tdata  = {16'($urandom), $urandom};
        tick();
        chk("dem_valid_gap", 64'(dem_valid), 64'(0));
      end
      if (k < 200)       d = (48'(k) << 24) | 48'($urandom_range(0, 32'h00FF_FFFF));
      else if (k == 200) d = 48'h7FFF_FFFF_FFFF;
      else               d = {16'($urandom), $urandom};
      fir_m_tvalid = 1'b1;
      fir_m_tdata  = d;
      emit_now = (k >= WARMUP) && (((k - WARMUP) % DECIM) == 0);
      v = ref_shift(d);
      tick();
      chk("dem_valid", 64'(dem_valid), 64'(emit_now));
      if (emit_now) begin
        chk("dem_data", 64'(dem_data), 64'(ref_out(v)));
`ifdef JIETIAO_SAT_EN
        if (v > 32767 || v < -32768) exp_sat = 1'b1;
`endif
        if (k < 200) begin
          n17++;
          if (pass == 0) q0.push_back(dem_data);
          else           q1.push_back(dem_data);
          if (n17 == 1) chk("first_strobe", 64'(dem_data), 64'(64));
        end
        if (k == 200) chk("sat_value", 64'(dem_data), 64'(SAT_EXP));
        $display("strobe pass=%0d beat=%0d data=%04h", pass, k, dem_data);
      end
`ifdef JIETIAO_SAT_EN
      chk("sat_err", 64'(sat_err), 64'(exp_sat));
`endif
    end
    fir_m_tvalid = 1'b0;
    chk("strobe_count", 64'(n17), 64'(17));
  endtask

  // Stop after nsamp products; expect nsamp products, then WARMUP accepted zeros, then IDLE
  task automatic run_flush(input int nsamp);
    int prod;
    int zeros;
    bit done;
    bit early;
    prod = 0; zeros = 0; done = 1'b0; early = 1'b0;
    sample_valid = 1'b0;
    fir_s_tready = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    for (int step = 0; step < 400 && !done; step++) begin
      sample_valid = (step < nsamp) || (step > nsamp && $urandom_range(0, 1) == 1);
      stop         = (step == nsamp);
      fir_s_tready = feed_zero ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (fir_s_tvalid && fir_s_tready) begin
        if (feed_zero) begin
          zeros++;
          if (prod != nsamp) early = 1'b1;
        end else begin
          prod++;
        end
      end
      if (step > nsamp && !busy) done = 1'b1;
      tick();
    end
    sample_valid = 1'b0;
    stop         = 1'b0;
    fir_s_tready = 1'b1;
    chk("flush_done", 64'(done), 64'(1));
    chk("flush_products", 64'(prod), 64'(nsamp));
    chk("flush_zeros", 64'(zeros), 64'(WARMUP));
    chk("flush_order", 64'(early), 64'(0));
    chk("flush_busy", 64'(busy), 64'(0));
    chk("flush_feed_zero", 64'(feed_zero), 64'(0));
    $display("flush nsamp=%0d products=%0d zeros=%0d", nsamp, prod, zeros);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired cycle=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; start = 1'b1; stop = 1'b0; sample_valid = 1'b0;
    fir_s_tready = 1'b1; fir_m_tvalid = 1'b0; fir_m_tdata = '0;
    exp_drop = 1'b0;
`ifdef JIETIAO_SAT_EN
    exp_sat = 1'b0;
`endif

    // Reset held with start asserted
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("rst_busy", 64'(busy), 64'(0));
      chk("rst_tvalid", 64'(fir_s_tvalid), 64'(0));
      chk("rst_feed_zero", 64'(feed_zero), 64'(0));
      chk("rst_dem_valid", 64'(dem_valid), 64'(0));
      chk("rst_dem_data", 64'(dem_data), 64'(0));
      chk("rst_drop", 64'(drop_err), 64'(0));
    end
    rst = 1'b1; start = 1'b0;
    tick();
    chk("idle_busy", 64'(busy), 64'(0));

    // IDLE ignores samples, FIR beats and stop
    sample_valid = 1'b1; fir_m_tvalid = 1'b1; fir_m_tdata = 48'h0001_0000_0000;
    tick();
    sample_valid = 1'b0; fir_m_tvalid = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      chk("idle_sample", 64'(fir_s_tvalid), 64'(0));
      chk("idle_dem", 64'(dem_valid), 64'(0));
      tick();
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("idle_stop", 64'(busy), 64'(0));

    // start and stop together: start wins, stays in RUN (no zero feeding)
    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    chk("start_busy", 64'(busy), 64'(1));
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("start_stop_run", 64'(feed_zero), 64'(0));
    end
    $display("phase start: RUN entered cycle=%0d", cyc);

    // Alignment: single sample
    sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      chk("align", 64'(fir_s_tvalid), 64'(i == MULT_LAT));
      tick();
    end
    chk("align_no_drop", 64'(drop_err), 64'(0));

    // Randomized samples and tready against the latency/drop model
    for (int i = 0; i < 300; i++) begin
      bit sv;
      bit tr;
      sv = ($urandom_range(0, 2) == 0);
      tr = ($urandom_range(0, 9) != 0);
      chk("rand_tvalid", 64'(fir_s_tvalid), 64'(exp_tv[cyc]));
      sample_valid = sv;
      fir_s_tready = tr;
      if (sv) exp_tv[cyc + MULT_LAT] = 1'b1;
      if (exp_tv[cyc] && !tr) exp_drop = 1'b1;
      tick();
      chk("rand_drop", 64'(drop_err), 64'(exp_drop));
    end
    sample_valid = 1'b0;
    fir_s_tready = 1'b1;
    $display("phase random: drop_err=%0d", drop_err);

    // Warm-up, decimation, rescale, saturation
    run_out(0);

    // Flush after 10 samples
    run_flush(10);

    // Mid-flush reset
    start = 1'b1;
    tick();
    start = 1'b0;
    sample_valid = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    sample_valid = 1'b0;
    stop = 1'b1;
    tick();
    stop = 1'b0;
    wcnt = 0;
    while (!feed_zero && wcnt < 20) begin
      tick();
      wcnt++;
    end
    chk("midrst_reach_flush", 64'(feed_zero), 64'(1));
    for (int i = 0; i < 5; i++) tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk("midrst_busy", 64'(busy), 64'(0));
    chk("midrst_feed_zero", 64'(feed_zero), 64'(0));
    chk("midrst_tvalid", 64'(fir_s_tvalid), 64'(0));
    chk("midrst_drop", 64'(drop_err), 64'(0));
    chk("midrst_dem_data", 64'(dem_data), 64'(0));
`ifdef JIETIAO_SAT_EN
    exp_sat = 1'b0;
    chk("midrst_sat", 64'(sat_err), 64'(0));
`endif
    tick();
    chk("midrst_stay_idle", 64'(busy), 64'(0));
    $display("phase midrst: reset applied cycle=%0d", cyc);

    // Restart; directed drop at the aligned cycle
    start = 1'b1;
    tick();
    start = 1'b0;
    sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
    tick();
    tick();
    chk("drop_aligned_tvalid", 64'(fir_s_tvalid), 64'(1));
    chk("drop_before", 64'(drop_err), 64'(0));
    fir_s_tready = 1'b0;
    tick();
    fir_s_tready = 1'b1;
    chk("drop_set", 64'(drop_err), 64'(1));

    // Restarted output must match the first run
    run_out(1);
    chk("restart_count", 64'(q1.size()), 64'(q0.size()));
    for (int i = 0; i < q0.size() && i < q1.size(); i++) begin
      chk("restart_value", 64'(q1[i]), 64'(q0[i]));
    end
    chk("drop_sticky", 64'(drop_err), 64'(1));

    // Flush again: zero counter restarted from zero
    run_flush(3);
    chk("drop_sticky_end", 64'(drop_err), 64'(1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
